// File: rtl/sigma_pkg.sv
// Shared types and signed-magnitude helpers for the sigma_stream slice.
// The helpers work on a fixed wide word; callers pass the real width n.
package sigma_pkg;

   localparam int unsigned N_DEF     = 32;
   localparam int unsigned F_DEF     = 16;
   localparam int unsigned LANES_DEF = 4;
   localparam int unsigned DEPTH_DEF = 32;
   localparam int unsigned MAXW      = 128;

   typedef enum logic {ACC, HOLD} state_t;

   // n-bit signed magnitude (zero-extended into x) -> two's complement; -0 maps to 0.
   function automatic logic signed [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] x,
                                                       input int unsigned   n);
      logic [MAXW-1:0] mag;
      mag = x & ((MAXW'(1) << (n - 1)) - MAXW'(1));
      return x[n-1] ? -$signed(mag) : $signed(mag);
   endfunction

   // Two's complement -> n-bit signed magnitude with saturation.
   // Result packs {ovf, data}: bits n-1:0 are the word, bit n is the overflow flag.
   function automatic logic [MAXW-1:0] tc_to_sm_sat(input logic signed [MAXW-1:0] s,
                                                    input int unsigned          n);
      logic [MAXW-1:0] lim;
      logic [MAXW-1:0] mag;
      logic [MAXW-1:0] r;
      lim = (MAXW'(1) << (n - 1)) - MAXW'(1);
      mag = s[MAXW-1] ? $unsigned(-s) : $unsigned(s);
      r   = '0;
      if (mag > lim) begin
         r    = lim;
         r[n] = 1'b1;
      end else begin
         r = mag;
      end
      r[n-1] = s[MAXW-1] && (mag != '0);
      return r;
   endfunction

endpackage

// File: rtl/sigma_lane_tree.sv
// Combinational pairwise adder tree over LANES two's-complement terms.
module sigma_lane_tree #(
   parameter int unsigned W     = 32,
   parameter int unsigned LANES = 4
) (
   input  logic signed [W-1:0]                terms [LANES],
   output logic signed [W+$clog2(LANES)-1:0]  sum
);

   localparam int unsigned OW = W + $clog2(LANES);

   // Each pass halves the live node count, pairing neighbours in place.
   always_comb begin
      logic signed [OW-1:0] t [LANES];
      for (int unsigned i = 0; i < LANES; i++) t[i] = OW'(terms[i]);
      for (int unsigned w = LANES / 2; w >= 1; w = w / 2) begin
         for (int unsigned i = 0; i < w; i++) t[i] = t[2*i] + t[2*i+1];
      end
      sum = t[0];
   end

endmodule

// File: rtl/sigma_stream.sv
// Streaming signed-magnitude summer: DEPTH elements in LANES-wide beats,
// one saturated signed-magnitude result per block, held until accepted.
module sigma_stream
   import sigma_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned F     = F_DEF,
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_data [LANES],
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out_data,
   output logic         out_ovf,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int unsigned TW    = N + $clog2(LANES);
   localparam int unsigned AW    = N + $clog2(DEPTH) + 1;
   localparam int unsigned BEATS = DEPTH / LANES;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (F >= N) begin : g_chk_f
      $error("sigma_stream: F must be smaller than N");
   end
   if ((LANES & (LANES - 1)) != 0 || LANES < 1 || LANES > 32) begin : g_chk_lanes
      $error("sigma_stream: LANES must be a power of two in 1..32");
   end
   if (DEPTH < LANES || (DEPTH % LANES) != 0) begin : g_chk_depth
      $error("sigma_stream: DEPTH must be a multiple of LANES");
   end
   if (AW >= MAXW) begin : g_chk_maxw
      $error("sigma_stream: accumulator wider than package helper word");
   end

   state_t               state, state_nx;
   logic [CW-1:0]        cnt;
   logic signed [AW-1:0] acc, acc_next;
   logic signed [N-1:0]  lane_tc [LANES];
   logic signed [TW-1:0] beat_sum;
   logic [N:0]           res;
   logic                 last;

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++)
         lane_tc[i] = N'(sm_to_tc(MAXW'(in_data[i]), N));
   end

   sigma_lane_tree #(.W(N), .LANES(LANES)) u_tree (
      .terms (lane_tc),
      .sum   (beat_sum)
   );

   assign acc_next  = acc + AW'(beat_sum);
   assign res       = (N + 1)'(tc_to_sm_sat(MAXW'(acc_next), N));
   assign last      = (cnt == CW'(BEATS - 1));
   assign in_ready  = (state == ACC);
   assign out_valid = (state == HOLD);

   always_comb begin
      state_nx = state;
      case (state)
         ACC:     if (in_valid && last) state_nx = HOLD;
         HOLD:    if (out_ready)        state_nx = ACC;
         default: state_nx = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nx;
   end

   // Accumulator and count are cleared as the result is captured, so ACC is
   // re-entered clean on the handshake without a separate clear step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc      <= '0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if (state == ACC && in_valid) begin
         if (last) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= res[N-1:0];
            out_ovf  <= res[N];
         end else begin
            cnt <= cnt + CW'(1);
            acc <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_sigma_stream.sv
// Directed bench for sigma_stream at N=16, F=8, LANES=4, DEPTH=8 (1.0 = 0x0100).
module tb_sigma_stream;

   localparam int unsigned N     = 16;
   localparam int unsigned F     = 8;
   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] in_data [LANES];
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_ovf;
   logic         out_valid;
   logic         out_ready = 1'b1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sigma_stream #(.N(N), .F(F), .LANES(LANES), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [N-1:0] v);
      for (int i = 0; i < LANES; i++) in_data[i] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [N-1:0] v);
      fill(v);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic [N-1:0] d, input logic o);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"},  32'(out_data),  32'(d));
      check({tag, "_ovf"},   32'(out_ovf),   32'(o));
   endtask

   initial begin
      logic [5:0] tp_exp;
      fill('0);
      #12;
      check("rst_ready", 32'(in_ready),  32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data",  32'(out_data),  32'h0);
      check("rst_ovf",   32'(out_ovf),   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // basic sum, single-cycle valid with out_ready high
      beat(16'h0100);
      check("t1_mid_valid", 32'(out_valid), 32'd0);
      beat(16'h0100);
      result("t1", 16'h0800, 1'b0);
      tick();
      check("t1_after_valid", 32'(out_valid), 32'd0);
      check("t1_after_ready", 32'(in_ready),  32'd1);

      // cancellation must give +0
      beat(16'h0100);
      beat(16'h8100);
      result("t2", 16'h0000, 1'b0);
      tick();

      // saturation both signs
      beat(16'h7FFF);
      beat(16'h7FFF);
      result("t3p", 16'h7FFF, 1'b1);
      tick();
      beat(16'hFFFF);
      beat(16'hFFFF);
      result("t3n", 16'hFFFF, 1'b1);
      tick();

      // backpressure: hold stable, input ignored while holding
      out_ready = 1'b0;
      beat(16'h8080);
      beat(16'h8080);
      fill(16'h7FFF);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("t4_hold_data",  32'(out_data),  32'h8400);
         check("t4_hold_ovf",   32'(out_ovf),   32'd0);
         check("t4_hold_ready", 32'(in_ready),  32'd0);
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t4_rel_ready", 32'(in_ready),  32'd1);
      check("t4_rel_valid", 32'(out_valid), 32'd0);

      // reset mid-accumulation discards the partial sum
      beat(16'h0100);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      beat(16'h0100);
      check("t5_mid_valid", 32'(out_valid), 32'd0);
      beat(16'h0100);
      result("t5", 16'h0800, 1'b0);
      tick();

      // reset while a result is pending drops it
      out_ready = 1'b0;
      beat(16'h7FFF);
      beat(16'h7FFF);
      check("t5h_pend_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5h_rst_valid", 32'(out_valid), 32'd0);
      check("t5h_rst_data",  32'(out_data),  32'h0);
      check("t5h_rst_ovf",   32'(out_ovf),   32'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // gapped input: only accepted beats count
      fill(16'h0040);
      in_valid = 1'b1;
      tick();
      check("t6_b1_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      fill(16'h7FFF);
      tick();
      check("t6_gap_valid", 32'(out_valid), 32'd0);
      fill(16'h0040);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      result("t6", 16'h0200, 1'b0);
      tick();

      // sustained stream: one result every three cycles
      tp_exp = 6'b010010;
      fill(16'h0100);
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("tp_valid", 32'(out_valid), 32'(tp_exp[5-k]));
         if (tp_exp[5-k]) check("tp_data", 32'(out_data), 32'h0800);
      end
      in_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
